// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLB maintenance ops: owns the TLB search/read/write ports while an op is in flight.
// INVTLB is executed as a one-entry-per-cycle walk; TLBFILL picks its target index round-robin.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [2:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_va,
    input  logic [IDXW-1:0] csr_index,
    input  logic            csr_ne,
    input  logic [9:0]      csr_asid,
    input  logic [18:0]     csr_vppn,
    output logic            busy,
    output logic [18:0]     tlb_s_vppn,
    output logic [9:0]      tlb_s_asid,
    input  logic [IDXW-1:0] tlb_s_index,
    input  logic            tlb_s_ne,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic            tlb_r_e,
    input  logic            tlb_r_g,
    input  logic [9:0]      tlb_r_asid,
    input  logic [18:0]     tlb_r_vppn,
    output logic            tlb_w_en,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_w_e,
    output logic            tlb_inv_en,
    output logic [IDXW-1:0] tlb_inv_index,
    output logic            rd_capture,
    output logic            done_valid,
    output logic            done_err,
    output logic            done_ne,
    output logic [IDXW-1:0] done_index
);
    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WALK, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_op;
    logic [2:0]      r_inv_op;
    logic [9:0]      r_inv_asid;
    logic [18:0]     r_inv_va;
    logic [IDXW-1:0] r_fill_ptr;
    logic [IDXW-1:0] r_walk_idx;
    logic [IDXW-1:0] r_done_index;
    logic            r_done_ne;
    logic            r_err;
    logic            w_accept;
    logic            w_match;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tlb_s_vppn = csr_vppn;
    assign tlb_s_asid = csr_asid;

    // Entry-match rule for the INVTLB walk, evaluated on the entry under walk_idx
    always_comb begin
        w_match = 1'b0;
        case (r_inv_op)
            3'd0, 3'd1: w_match = 1'b1;
            3'd2:       w_match = tlb_r_g;
            3'd3:       w_match = !tlb_r_g;
            3'd4:       w_match = !tlb_r_g && (tlb_r_asid == r_inv_asid);
            3'd5:       w_match = !tlb_r_g && (tlb_r_asid == r_inv_asid) && (tlb_r_vppn == r_inv_va);
            3'd6:       w_match = (tlb_r_g || (tlb_r_asid == r_inv_asid)) && (tlb_r_vppn == r_inv_va);
            default:    w_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_SRCH;
            r_inv_op     <= 3'd0;
            r_inv_asid   <= '0;
            r_inv_va     <= '0;
            r_fill_ptr   <= '0;
            r_walk_idx   <= '0;
            r_done_index <= '0;
            r_done_ne    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op       <= req_op;
                r_inv_op   <= inv_op;
                r_inv_asid <= inv_asid;
                r_inv_va   <= inv_va;
                r_err      <= (req_op == OP_INV) && (inv_op == 3'd7);
                r_done_ne  <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                if (r_op == OP_SRCH) begin
                    r_done_ne    <= tlb_s_ne;
                    r_done_index <= tlb_s_index;
                end
                if (r_op == OP_RD) begin
                    r_done_ne <= !tlb_r_e;
                end
                // TLBNUM is a power of two, so the natural wrap is the round-robin wrap
                if (r_op == OP_FILL) begin
                    r_fill_ptr <= r_fill_ptr + 1'b1;
                end
            end
            if (r_state == S_WALK) begin
                r_walk_idx <= r_walk_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        tlb_r_index   = csr_index;
        tlb_w_en      = 1'b0;
        tlb_w_index   = csr_index;
        tlb_w_e       = !csr_ne;
        tlb_inv_en    = 1'b0;
        tlb_inv_index = r_walk_idx;
        rd_capture    = 1'b0;
        done_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = ((req_op == OP_INV) && (inv_op != 3'd7)) ? S_WALK : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_DONE;
                case (r_op)
                    OP_RD:   rd_capture = 1'b1;
                    OP_WR:   tlb_w_en = 1'b1;
                    OP_FILL: begin
                        tlb_w_en    = 1'b1;
                        tlb_w_index = r_fill_ptr;
                    end
                    default: ;
                endcase
            end
            S_WALK: begin
                tlb_r_index = r_walk_idx;
                tlb_inv_en  = tlb_r_e && w_match;
                if (r_walk_idx == IDXW'(TLBNUM - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_valid   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign done_err   = (r_state == S_DONE) && r_err;
    assign done_ne    = r_done_ne;
    assign done_index = r_done_index;
endmodule
